cpu_bus_memory: RTL and testbench

//   Memory subsystem on the 16-bit CPU external bus, downstream of the CPU's

---
 rtl/cpu_bus_memory.sv | 166 ++++++++++++++++
 tb/tb_cpu_bus_memory.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_bus_memory.sv
// cpu_bus_memory: RAM plus memory-mapped I/O behind the CPU's external bus.
// Reads finish in the same cycle, because the CPU inserts no wait states.
// Writes take effect at the next rising clock edge.
// The I/O block holds these registers:
//   - an output port
//   - a TX FIFO that drains to a valid/ready stream
//   - a status register with sticky error flags
//   - a free-running cycle counter
module cpu_bus_memory #(
  parameter int unsigned ADDR_W     = 8,
  parameter logic [15:0] IO_BASE    = 16'hFF00,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr_bus,
  input  logic        rd_mem,
  input  logic        wr_mem,
  inout  wire  [15:0] data_bus,
  output logic [15:0] port_out,
  output logic [15:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] CNT_FULL = FIFO_DEPTH[PTR_W:0];

  localparam logic [15:0] OFF_PORT   = 16'd0;
  localparam logic [15:0] OFF_TXDAT  = 16'd1;
  localparam logic [15:0] OFF_STATUS = 16'd2;
  localparam logic [15:0] OFF_CYCLE  = 16'd3;

  // Storage and state
  logic [15:0]      r_ram  [2**ADDR_W];
  logic [15:0]      r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic [15:0]      r_port;
  logic [15:0]      r_cycle;
  logic             r_err;
  logic             r_ovf;

  // Bus qualification and address decode
  logic        w_rd_ok;
  logic        w_wr_ok;
  logic        w_bus_err;
  logic        w_is_io;
  logic [15:0] w_io_off;
  logic        w_wr_ram;
  logic        w_wr_port;
  logic        w_wr_txdat;
  logic        w_wr_status;
  logic        w_wr_cycle;
  logic [15:0] w_rd_data;

  // FIFO handshake
  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_ovf_set;

  assign w_rd_ok   = rd_mem & ~wr_mem;
  assign w_wr_ok   = wr_mem & ~rd_mem;
  assign w_bus_err = rd_mem & wr_mem;
  assign w_is_io   = (addr_bus >= IO_BASE);
  assign w_io_off  = addr_bus - IO_BASE;

  assign w_wr_ram    = w_wr_ok & ~w_is_io;
  assign w_wr_port   = w_wr_ok & w_is_io & (w_io_off == OFF_PORT);
  assign w_wr_txdat  = w_wr_ok & w_is_io & (w_io_off == OFF_TXDAT);
  assign w_wr_status = w_wr_ok & w_is_io & (w_io_off == OFF_STATUS);
  assign w_wr_cycle  = w_wr_ok & w_is_io & (w_io_off == OFF_CYCLE);

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_FULL);
  assign w_pop   = ~w_empty & tx_ready;
  // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
  assign w_push    = w_wr_txdat & (~w_full | w_pop);
  assign w_ovf_set = w_wr_txdat & w_full & ~w_pop;

  assign port_out = r_port;
  assign tx_valid = ~w_empty;
  assign tx_data  = r_fifo[r_rd_ptr];

  // Select the read word; RAM addresses alias above the RAM depth
  always_comb begin
    // NOTE: give every always_comb output a default first so that no path can infer a latch.
    w_rd_data = '0;
    if (!w_is_io) begin
      w_rd_data = r_ram[addr_bus[ADDR_W-1:0]];
    end else begin
      case (w_io_off)
        OFF_PORT:   w_rd_data = r_port;
        OFF_STATUS: w_rd_data = {12'b0, r_ovf, r_err, w_full, w_empty};
        OFF_CYCLE:  w_rd_data = r_cycle;
        default:    w_rd_data = '0;
      endcase
    end
  end

  // The bus is driven only during a valid read; it floats at all other times
  assign data_bus = w_rd_ok ? w_rd_data : {16{1'bz}};

  // RAM write port; a write is suppressed while reset is asserted
  always_ff @(posedge clk) begin
    // NOTE: memory arrays get no reset so that they map onto RAM; only the control state is reset.
    if (!reset && w_wr_ram) begin
      r_ram[addr_bus[ADDR_W-1:0]] <= data_bus;
    end
  end

  // FIFO storage write; entries are qualified by the occupancy count, not by reset
  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_fifo[r_wr_ptr] <= data_bus;
    end
  end

  // FIFO pointers and occupancy; reset also discards a pop issued in the same cycle
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Output port, cycle counter and sticky flags; a set wins over a clear
  always_ff @(posedge clk) begin
    if (reset) begin
      r_port  <= '0;
      r_cycle <= '0;
      r_err   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_wr_port) r_port <= data_bus;

      r_cycle <= w_wr_cycle ? 16'd0 : r_cycle + 16'd1;

      if (w_bus_err) begin
        r_err <= 1'b1;
      end else if (w_wr_status && data_bus[2]) begin
        r_err <= 1'b0;
      end

      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (w_wr_status && data_bus[3]) begin
        r_ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cpu_bus_memory.sv
// tb_cpu_bus_memory: directed checks for cpu_bus_memory. It uses a table of bus
// cycles plus hand-written FIFO, error, counter and reset sequences. The bus
// carries weak pull-ups, so a floating data_bus reads as 16'hFFFF.
module tb_cpu_bus_memory;

  localparam logic [15:0] A_PORT   = 16'hFF00;
  localparam logic [15:0] A_TXDAT  = 16'hFF01;
  localparam logic [15:0] A_STATUS = 16'hFF02;
  localparam logic [15:0] A_CYCLE  = 16'hFF03;
  localparam logic [15:0] FLOAT    = 16'hFFFF;

  logic        clk;
  logic        reset;
  logic [15:0] addr_bus;
  logic        rd_mem;
  logic        wr_mem;
  wire  [15:0] data_bus;
  logic [15:0] port_out;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;

  logic        tb_drive;
  logic [15:0] tb_wdata;

  int n_tests = 0;
  int n_fail  = 0;

  assign data_bus = tb_drive ? tb_wdata : {16{1'bz}};

  for (genvar g = 0; g < 16; g++) begin : g_pull
    pullup (data_bus[g]);
  end

  cpu_bus_memory dut (
    .clk      (clk),
    .reset    (reset),
    .addr_bus (addr_bus),
    .rd_mem   (rd_mem),
    .wr_mem   (wr_mem),
    .data_bus (data_bus),
    .port_out (port_out),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [15:0] addr;
    logic        rd;
    logic        wr;
    logic [15:0] wdata;
    logic        chk_bus;
    logic [15:0] exp_bus;
    logic [15:0] exp_port;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    rd_mem   = 1'b0;
    wr_mem   = 1'b0;
    tb_drive = 1'b0;
  endtask

  task automatic bus_write(input logic [15:0] addr, input logic [15:0] data);
    addr_bus = addr;
    rd_mem   = 1'b0;
    wr_mem   = 1'b1;
    tb_wdata = data;
    tb_drive = 1'b1;
    tick();
    bus_idle();
  endtask

  task automatic bus_read(input logic [15:0] addr, input logic [15:0] exp, input string name);
    addr_bus = addr;
    rd_mem   = 1'b1;
    wr_mem   = 1'b0;
    tb_drive = 1'b0;
    #1;
    check(name, data_bus, exp);
    tick();
    bus_idle();
  endtask

  task automatic add_vec(input logic [15:0] addr, input logic rd, input logic wr,
                         input logic [15:0] wdata, input logic chk_bus,
                         input logic [15:0] exp_bus, input logic [15:0] exp_port,
                         input string name);
    vec_t v;
    v.addr     = addr;
    v.rd       = rd;
    v.wr       = wr;
    v.wdata    = wdata;
    v.chk_bus  = chk_bus;
    v.exp_bus  = exp_bus;
    v.exp_port = exp_port;
    v.name     = name;
    vecs.push_back(v);
  endtask

  initial begin
    logic [15:0] exp_seq [4];

    reset    = 1'b1;
    addr_bus = 16'h0000;
    tx_ready = 1'b0;
    tb_wdata = 16'h0000;
    bus_idle();

    //            addr      rd    wr    wdata     chk   exp_bus   exp_port  name
    add_vec(16'h0005, 1'b0, 1'b1, 16'h1234, 1'b0, 16'h0000, 16'h0000, "ram_wr_0005");
    add_vec(16'h0005, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h1234, 16'h0000, "ram_rd_0005");
    add_vec(16'h0005, 1'b0, 1'b0, 16'h0000, 1'b1, FLOAT,    16'h0000, "idle_float");
    add_vec(16'h0105, 1'b0, 1'b1, 16'hABCD, 1'b0, 16'h0000, 16'h0000, "ram_wr_alias");
    add_vec(16'h0005, 1'b1, 1'b0, 16'h0000, 1'b1, 16'hABCD, 16'h0000, "ram_rd_alias");
    add_vec(16'hFEFF, 1'b0, 1'b1, 16'h7777, 1'b0, 16'h0000, 16'h0000, "ram_wr_below_io");
    add_vec(16'h00FF, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h7777, 16'h0000, "ram_rd_top_word");
    add_vec(A_PORT,   1'b0, 1'b1, 16'hBEEF, 1'b0, 16'h0000, 16'hBEEF, "port_wr");
    add_vec(A_PORT,   1'b1, 1'b0, 16'h0000, 1'b1, 16'hBEEF, 16'hBEEF, "port_rd");
    add_vec(A_TXDAT,  1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'hBEEF, "txdat_rd_zero");
    add_vec(16'hFF10, 1'b0, 1'b1, 16'h5555, 1'b0, 16'h0000, 16'hBEEF, "unmapped_wr");
    add_vec(16'hFF10, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'hBEEF, "unmapped_rd");
    add_vec(A_STATUS, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0001, 16'hBEEF, "status_empty");
    add_vec(16'hFFFF, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'hBEEF, "top_io_rd_zero");
    add_vec(A_PORT,   1'b0, 1'b0, 16'h0000, 1'b1, FLOAT,    16'hBEEF, "idle_io_float");

    // Reset state
    repeat (2) tick();
    reset = 1'b0;
    check("reset_port", port_out, 16'h0000);
    check("reset_tx_valid", {15'b0, tx_valid}, 16'h0000);
    bus_read(A_CYCLE, 16'h0000, "reset_cycle");
    #1;
    check("reset_bus_float", data_bus, FLOAT);
    bus_read(A_STATUS, 16'h0001, "reset_status");

    // Table-driven bus cycles
    foreach (vecs[i]) begin
      addr_bus = vecs[i].addr;
      rd_mem   = vecs[i].rd;
      wr_mem   = vecs[i].wr;
      tb_wdata = vecs[i].wdata;
      tb_drive = vecs[i].wr;
      #1;
      if (vecs[i].chk_bus) check({vecs[i].name, "_bus"}, data_bus, vecs[i].exp_bus);
      tick();
      check({vecs[i].name, "_port"}, port_out, vecs[i].exp_port);
      bus_idle();
    end

    // FIFO overflow while the consumer is stalled, then drain
    tx_ready = 1'b0;
    for (int i = 1; i <= 5; i++) bus_write(A_TXDAT, 16'h00A0 + 16'(i));
    bus_read(A_STATUS, 16'h000A, "status_full_ovf");
    tx_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("drain_valid", {15'b0, tx_valid}, 16'h0001);
      check("drain_data", tx_data, 16'h00A0 + 16'(i));
      tick();
    end
    check("drain_empty", {15'b0, tx_valid}, 16'h0000);
    bus_read(A_STATUS, 16'h0009, "status_empty_ovf");
    bus_write(A_STATUS, 16'h0008);
    bus_read(A_STATUS, 16'h0001, "status_ovf_cleared");

    // Push into a full FIFO while it pops in the same cycle
    tx_ready = 1'b0;
    for (int i = 1; i <= 4; i++) bus_write(A_TXDAT, 16'h00B0 + 16'(i));
    bus_read(A_STATUS, 16'h0002, "status_full");
    tx_ready = 1'b1;
    bus_write(A_TXDAT, 16'h00B0);
    tx_ready = 1'b0;
    bus_read(A_STATUS, 16'h0002, "status_full_no_ovf");
    exp_seq[0] = 16'h00B2;
    exp_seq[1] = 16'h00B3;
    exp_seq[2] = 16'h00B4;
    exp_seq[3] = 16'h00B0;
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("pushpop_valid", {15'b0, tx_valid}, 16'h0001);
      check("pushpop_data", tx_data, exp_seq[i]);
      tick();
    end
    check("pushpop_empty", {15'b0, tx_valid}, 16'h0000);

    // A push into an empty FIFO must not fall through in the same cycle
    addr_bus = A_TXDAT;
    wr_mem   = 1'b1;
    tb_wdata = 16'h00C1;
    tb_drive = 1'b1;
    #1;
    check("no_fallthrough", {15'b0, tx_valid}, 16'h0000);
    tick();
    bus_idle();
    check("push_empty_valid", {15'b0, tx_valid}, 16'h0001);
    check("push_empty_data", tx_data, 16'h00C1);
    tick();
    check("push_empty_popped", {15'b0, tx_valid}, 16'h0000);
    tx_ready = 1'b0;

    // Bus error: simultaneous read and write strobes
    addr_bus = 16'h0005;
    rd_mem   = 1'b1;
    wr_mem   = 1'b1;
    tb_wdata = 16'h0000;
    tb_drive = 1'b1;
    tick();
    tb_drive = 1'b0;
    #1;
    check("buserr_no_drive", data_bus, FLOAT);
    tick();
    bus_idle();
    bus_read(16'h0005, 16'hABCD, "buserr_ram_kept");
    bus_read(A_STATUS, 16'h0005, "status_err");
    bus_write(A_STATUS, 16'h0004);
    bus_read(A_STATUS, 16'h0001, "status_err_cleared");

    // Cycle counter: clear, count ten cycles, then wrap from 16'hFFFF
    bus_write(A_CYCLE, 16'hFFFF);
    repeat (10) tick();
    bus_read(A_CYCLE, 16'd10, "cycle_ten");
    bus_write(A_CYCLE, 16'h1234);
    repeat (65535) tick();
    bus_read(A_CYCLE, 16'hFFFF, "cycle_max");
    bus_read(A_CYCLE, 16'h0000, "cycle_wrap");

    // Mid-test reset with a write and a pop pending in the reset cycle
    bus_write(A_PORT, 16'h5A5A);
    check("port_before_reset", port_out, 16'h5A5A);
    bus_write(A_TXDAT, 16'h00D1);
    check("valid_before_reset", {15'b0, tx_valid}, 16'h0001);
    addr_bus = 16'h0000;
    rd_mem   = 1'b1;
    wr_mem   = 1'b1;
    tick();
    bus_idle();
    reset    = 1'b1;
    tx_ready = 1'b1;
    addr_bus = 16'h0005;
    wr_mem   = 1'b1;
    tb_wdata = 16'h9999;
    tb_drive = 1'b1;
    tick();
    reset    = 1'b0;
    tx_ready = 1'b0;
    bus_idle();
    check("midreset_port", port_out, 16'h0000);
    check("midreset_valid", {15'b0, tx_valid}, 16'h0000);
    bus_read(A_CYCLE, 16'h0000, "midreset_cycle");
    bus_read(A_STATUS, 16'h0001, "midreset_status");
    bus_read(16'h0005, 16'hABCD, "midreset_ram_kept");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
